// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor with elastic handshake and C/V/Z/N flags
// Optional macro CLA_PIPE_TAG_EN adds a 4-bit tag that travels alongside each operation.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef CLA_PIPE_TAG_EN
  input  logic [3:0]       in_tag,
  output logic [3:0]       out_tag,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
  } slice_t;

  // Fills in the sum bits of slice k on top of the partial result, one 4-bit CLA group at a time.
  function automatic slice_t do_slice(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                                      input logic [WIDTH-1:0] part, input logic c_in, input int k);
    slice_t     r;
    logic       c;
    logic [3:0] p, g, cv;
    logic       gg;
    int         base;
    r.sum  = part;
    c      = c_in;
    for (int j = 0; j < NG; j++) begin
      base  = k * SW + 4 * j;
      p     = op_a[base +: 4] ^ op_b[base +: 4];
      g     = op_a[base +: 4] & op_b[base +: 4];
      cv[0] = c;
      cv[1] = g[0] | (p[0] & c);
      cv[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      cv[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      gg    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      r.sum[base +: 4] = p ^ cv;
      c     = gg | ((&p) & c);
    end
    r.cout = c;
    return r;
  endfunction

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] adv;

  assign in_ready = !valid[0] || adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] src_a, src_b, src_s;
    logic             src_c, src_v;
    slice_t           res;
`ifdef CLA_PIPE_TAG_EN
    logic [3:0]       src_tag;
`endif

    // A stage moves whenever some stage at or after it has room, or the output drains.
    assign adv[k] = out_ready || !(&valid[STAGES-1:k]);

    if (k == 0) begin : g_in
      assign src_a = a;
      assign src_b = sub ? ~b : b;
      assign src_s = '0;
      assign src_c = sub ^ cin;
      assign src_v = in_valid;
`ifdef CLA_PIPE_TAG_EN
      assign src_tag = in_tag;
`endif
    end else begin : g_chain
      assign src_a = g_stage[k-1].g_reg.a_q;
      assign src_b = g_stage[k-1].g_reg.b_q;
      assign src_s = g_stage[k-1].g_reg.s_q;
      assign src_c = g_stage[k-1].g_reg.c_q;
      assign src_v = g_stage[k-1].g_reg.valid_q;
`ifdef CLA_PIPE_TAG_EN
      assign src_tag = g_stage[k-1].g_reg.tag_q;
`endif
    end

    assign res = do_slice(src_a, src_b, src_s, src_c, k);

    if (k < STAGES - 1) begin : g_reg
      logic [WIDTH-1:0] a_q, b_q, s_q;
      logic             c_q, valid_q;
`ifdef CLA_PIPE_TAG_EN
      logic [3:0]       tag_q;
`endif
      assign valid[k] = valid_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_q <= 1'b0;
          a_q     <= '0;
          b_q     <= '0;
          s_q     <= '0;
          c_q     <= 1'b0;
`ifdef CLA_PIPE_TAG_EN
          tag_q   <= '0;
`endif
        end else if (adv[k]) begin
          valid_q <= src_v;
          if (src_v) begin
            a_q   <= src_a;
            b_q   <= src_b;
            s_q   <= res.sum;
            c_q   <= res.cout;
`ifdef CLA_PIPE_TAG_EN
            tag_q <= src_tag;
`endif
          end
        end
      end
    end else begin : g_out
      assign valid[k] = out_valid;

      // Carry into the MSB is recovered from the sign bits: c_msb = a ^ b_eff ^ sum at bit WIDTH-1.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
          neg       <= 1'b0;
`ifdef CLA_PIPE_TAG_EN
          out_tag   <= '0;
`endif
        end else if (adv[k]) begin
          out_valid <= src_v;
          if (src_v) begin
            sum     <= res.sum;
            cout    <= res.cout;
            ovf     <= res.cout ^ (src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ res.sum[WIDTH-1]);
            zero    <= ~|res.sum;
            neg     <= res.sum[WIDTH-1];
`ifdef CLA_PIPE_TAG_EN
            out_tag <= src_tag;
`endif
          end
        end
      end
    end
  end

endmodule
